// File: rtl/ad5662_dac_writer_pkg.sv
// AD5662 DAC writer shared definitions:
// frame width, power-down codes and controller states.
package ad5662_dac_writer_pkg;

   localparam int FRAME_W = 24;

   typedef enum logic [1:0] {
      PD_NORMAL   = 2'b00,
      PD_1K_GND   = 2'b01,
      PD_100K_GND = 2'b10,
      PD_TRISTATE = 2'b11
   } pd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_GAP
   } state_e;

   function automatic logic [FRAME_W-1:0] make_frame(
      input logic [17:0] word
   );
      return {6'b0, word};
   endfunction

endpackage

// File: rtl/ad5662_dac_writer.sv
// AD5662 serial writer: sends {pd,dat} as a 24-bit SPI frame
// whenever it differs from the last completed frame.
module ad5662_dac_writer
   import ad5662_dac_writer_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int SYNC_IDLE = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dat,
   input  logic [1:0]  pd,
   output logic        busy,
   output logic        done,
   output logic        sclk,
   output logic        mosi,
   output logic        sync_n
);

   localparam int MAXC = (CLK_DIV > SYNC_IDLE) ? CLK_DIV : SYNC_IDLE;
   localparam int CW   = $clog2(MAXC);
   localparam int BW   = $clog2(FRAME_W);

   localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_END = CW'(SYNC_IDLE - 1);
   localparam logic [BW-1:0] BIT_END = BW'(FRAME_W - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      bit_q, bit_d;
   logic               ph_q, ph_d;
   logic [FRAME_W-1:0] sh_q, sh_d;
   logic [17:0]        word_q, word_d;
   logic [17:0]        last_q, last_d;
   logic               force_q, force_d;
   logic               busy_d, done_d, sclk_d, mosi_d, sync_n_d;
   logic [17:0]        req;
   logic               launch;

   assign req = {pd, dat};

   // The last gap cycle doubles as the first idle decision cycle.
   assign launch = (force_q || (req != last_q)) &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_GAP) && (cnt_q == GAP_END)));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      ph_d     = ph_q;
      sh_d     = sh_q;
      word_d   = word_q;
      last_d   = last_q;
      force_d  = force_q;
      busy_d   = busy;
      done_d   = 1'b0;
      sclk_d   = sclk;
      mosi_d   = mosi;
      sync_n_d = sync_n;
      unique case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_SETUP: begin
            if (cnt_q == DIV_END) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               bit_d   = '0;
               ph_d    = 1'b0;
               mosi_d  = sh_q[FRAME_W-1];
               sh_d    = sh_q << 1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != DIV_END) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (!ph_q) begin
                  ph_d   = 1'b1;
                  sclk_d = 1'b0;
               end else if (bit_q == BIT_END) begin
                  state_d  = ST_GAP;
                  sclk_d   = 1'b1;
                  sync_n_d = 1'b1;
                  mosi_d   = 1'b0;
                  done_d   = 1'b1;
                  last_d   = word_q;
                  force_d  = 1'b0;
               end else begin
                  ph_d   = 1'b0;
                  sclk_d = 1'b1;
                  bit_d  = bit_q + 1'b1;
                  mosi_d = sh_q[FRAME_W-1];
                  sh_d   = sh_q << 1;
               end
            end
         end
         ST_GAP: begin
            if (cnt_q != GAP_END) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (launch) begin
         state_d  = ST_SETUP;
         cnt_d    = '0;
         bit_d    = '0;
         ph_d     = 1'b0;
         word_d   = req;
         sh_d     = make_frame(req);
         sync_n_d = 1'b0;
         sclk_d   = 1'b1;
         mosi_d   = 1'b0;
         busy_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         ph_q    <= 1'b0;
         sh_q    <= '0;
         word_q  <= '0;
         last_q  <= '0;
         force_q <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         sclk    <= 1'b1;
         mosi    <= 1'b0;
         sync_n  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         ph_q    <= ph_d;
         sh_q    <= sh_d;
         word_q  <= word_d;
         last_q  <= last_d;
         force_q <= force_d;
         busy    <= busy_d;
         done    <= done_d;
         sclk    <= sclk_d;
         mosi    <= mosi_d;
         sync_n  <= sync_n_d;
      end
   end

endmodule

// File: tb/tb_ad5662_dac_writer.sv
// Bench for ad5662_dac_writer: default and fast instances decoded at
// the SPI pins and checked against an input-history reference model.
module tb_ad5662_dac_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset, busy, done, sclk, mosi, sync_n;
   logic [15:0] dat;
   logic [1:0]  pd;
   logic        reset_f, busy_f, done_f, sclk_f, mosi_f, sync_n_f;
   logic [15:0] dat_f;
   logic [1:0]  pd_f;

   ad5662_dac_writer u_dut (
      .clk(clk), .reset(reset), .dat(dat), .pd(pd),
      .busy(busy), .done(done), .sclk(sclk),
      .mosi(mosi), .sync_n(sync_n)
   );

   ad5662_dac_writer #(.CLK_DIV(2), .SYNC_IDLE(1)) u_fast (
      .clk(clk), .reset(reset_f), .dat(dat_f), .pd(pd_f),
      .busy(busy_f), .done(done_f), .sclk(sclk_f),
      .mosi(mosi_f), .sync_n(sync_n_f)
   );

   typedef struct {
      logic [23:0] frm;
      int          bits;
      int          fall;
      int          rise;
      logic        dn;
   } rec_t;

   rec_t        qa[$];
   rec_t        qb[$];
   logic [17:0] ha [0:32767];
   logic [17:0] hb [0:32767];

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Pin-level decoder, default instance
   logic        ps_a = 1'b1, pk_a = 1'b1, pb_a = 1'b0;
   int          nb_a = 0, fa = 0, nfall_a = 0, bfall_a = -1;
   logic [23:0] sa = '0;
   rec_t        ra;
   always @(negedge clk) begin
      ha[cyc[14:0]] = {pd, dat};
      if (ps_a && !sync_n) begin
         fa = cyc; nb_a = 0; sa = '0; nfall_a++;
      end else if (!sync_n && pk_a && !sclk) begin
         sa = {sa[22:0], mosi}; nb_a++;
      end
      if (!ps_a && sync_n) begin
         ra.frm = sa; ra.bits = nb_a; ra.fall = fa;
         ra.rise = cyc; ra.dn = done;
         qa.push_back(ra);
      end
      if (pb_a && !busy) bfall_a = cyc;
      ps_a = sync_n; pk_a = sclk; pb_a = busy;
   end

   // Pin-level decoder plus sclk half-period check, fast instance
   logic        ps_b = 1'b1, pk_b = 1'b1, first_b = 1'b1;
   int          nb_b = 0, fb = 0, run_b = 0, sbad_b = 0, nrun_b = 0;
   logic [23:0] sb = '0;
   rec_t        rb;
   always @(negedge clk) begin
      hb[cyc[14:0]] = {pd_f, dat_f};
      if (ps_b && !sync_n_f) begin
         fb = cyc; nb_b = 0; sb = '0; run_b = 1; first_b = 1'b1;
      end else if (!sync_n_f) begin
         if (sclk_f != pk_b) begin
            if (!first_b) begin
               nrun_b++;
               if (run_b != 2) sbad_b++;
            end
            first_b = 1'b0; run_b = 1;
         end else begin
            run_b++;
         end
         if (pk_b && !sclk_f) begin
            sb = {sb[22:0], mosi_f}; nb_b++;
         end
      end
      if (!ps_b && sync_n_f) begin
         rb.frm = sb; rb.bits = nb_b; rb.fall = fb;
         rb.rise = cyc; rb.dn = done_f;
         qb.push_back(rb);
      end
      ps_b = sync_n_f; pk_b = sclk_f;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_a(input int n, input int lim, input string tag);
      int i = 0;
      while (qa.size() < n && i < lim) begin
         tick(1); i++;
      end
      chk(tag, qa.size() >= n, 1);
   endtask

   initial begin
      rec_t        r, p;
      int          rel, rc, nf, s, stop;
      logic [15:0] r1, r2;
      logic [17:0] pv;

      reset = 1'b1; dat = 16'h7FFF; pd = 2'b00;
      reset_f = 1'b1; dat_f = 16'h0000; pd_f = 2'b00;
      tick(3);
      chk("rst_sclk", sclk, 1);
      chk("rst_mosi", mosi, 0);
      chk("rst_sync", sync_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      // first frame after reset
      reset = 1'b0; rel = cyc;
      wait_a(1, 400, "f0_seen");
      r = qa[0];
      chk("f0_data", r.frm, 24'h007FFF);
      chk("f0_bits", r.bits, 24);
      chk("f0_fall", r.fall - rel, 1);
      chk("f0_done", r.rise - r.fall, 196);
      chk("f0_dn", r.dn, 1);
      for (int i = 0; i < 50 && busy; i++) tick(1);
      @(negedge clk); #1;
      chk("f0_busy", bfall_a - r.rise, 8);

      // constant input: no activity
      nf = nfall_a;
      tick(1000);
      chk("hold_quiet", nfall_a, nf);

      // mid-frame changes
      r1 = 16'($urandom_range(0, 32766));
      dat = r1; s = qa.size();
      wait_a(s + 1, 400, "r1_seen");
      chk("r1_data", qa[s].frm, {8'h00, r1});
      dat = 16'h7FFF; nf = nfall_a;
      for (int i = 0; i < 400 && nfall_a == nf; i++) tick(1);
      chk("fall_7fff", nfall_a, nf + 1);
      tick(50); dat = 16'h1234;
      tick(80); dat = 16'hABCD;
      wait_a(s + 3, 700, "abcd_seen");
      chk("mid_keep", qa[s+1].frm, 24'h007FFF);
      chk("mid_next", qa[s+2].frm, 24'h00ABCD);
      chk("mid_gap", qa[s+2].fall - qa[s+1].rise, 8);
      tick(300);
      chk("no_1234", qa.size(), s + 3);

      // reset at bit 10
      r2 = 16'($urandom_range(0, 16'hABCC));
      dat = r2; nf = nfall_a; s = qa.size();
      for (int i = 0; i < 400 && nfall_a == nf; i++) tick(1);
      for (int i = 0; i < 300 && nb_a < 10; i++) tick(1);
      chk("abort_at10", nb_a, 10);
      reset = 1'b1; rc = cyc;
      tick(1);
      reset = 1'b0;
      wait_a(s + 2, 400, "reframe_seen");
      chk("abort_dn", qa[s].dn, 0);
      chk("abort_rise", qa[s].rise - rc, 1);
      chk("abort_bits", qa[s].bits, 10);
      chk("refr_data", qa[s+1].frm, {8'h00, r2});
      chk("refr_dn", qa[s+1].dn, 1);
      chk("refr_fall", qa[s+1].fall - qa[s].rise, 1);

      // power-down field change alone
      s = qa.size(); pd = 2'b11;
      wait_a(s + 1, 400, "pd_seen");
      chk("pd_data", qa[s].frm, {6'b0, 2'b11, r2});

      // random traffic against input history
      pd = 2'b00; s = qa.size();
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) pd = 2'($urandom_range(0, 3));
         dat = 16'($urandom);
         tick($urandom_range(1, 250));
      end
      tick(600);
      chk("rnd_count", qa.size() > s, 1);
      for (int i = s; i < qa.size(); i++) begin
         r = qa[i]; p = qa[i-1]; pv = p.frm[17:0];
         chk("rnd_data", r.frm, {6'b0, ha[r.fall-1]});
         chk("rnd_len", r.rise - r.fall, 196);
         chk("rnd_new", ha[r.fall-1] != pv, 1);
         if (ha[p.rise+7] != pv) begin
            chk("rnd_b2b", r.fall - p.rise, 8);
         end else begin
            chk("rnd_late", r.fall > p.rise + 8, 1);
            chk("rnd_held", ha[r.fall-2], pv);
         end
      end
      chk("rnd_last", qa[qa.size()-1].frm, {6'b0, pd, dat});

      // fast instance, input changing every cycle
      reset_f = 1'b0;
      stop = cyc + 20 * 99;
      while (cyc < stop) begin
         dat_f = dat_f + 16'($urandom_range(1, 600));
         tick(1);
      end
      tick(300);
      chk("fast_count", qb.size() >= 20, 1);
      for (int i = 0; i < qb.size(); i++) begin
         r = qb[i];
         chk("fast_data", r.frm, {6'b0, hb[r.fall-1]});
         chk("fast_bits", r.bits, 24);
         chk("fast_len", r.rise - r.fall, 98);
         chk("fast_dn", r.dn, 1);
         if (i > 0 && r.fall <= stop)
            chk("fast_space", r.fall - qb[i-1].fall, 99);
      end
      chk("fast_sclk", sbad_b, 0);
      chk("fast_runs", nrun_b > 0, 1);
      chk("fast_idle", busy_f, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
